// File: rtl/rs_drive_pkg.sv
// Shared types and helpers for the RS latch drive controller.
// Build option: RS_DRIVE_CTRL_SYNC_EN selects synchronised latch read-back in rs_drive_ctrl.
package rs_drive_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        VERIFY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic DIR_SET = 1'b1;
    localparam logic DIR_CLR = 1'b0;

    // Expected {q, qb} once the latch has taken the commanded direction.
    function automatic logic [1:0] target_pair(input logic dir);
        return (dir == DIR_SET) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rs_sync2.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset to 0.
module rs_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rs_drive_ctrl.sv
// Drives mutually exclusive s/r pulses into a NOR RS latch and confirms the result on q/qb.
// Define RS_DRIVE_CTRL_SYNC_EN to pass q/qb through 2-flop synchronisers before comparison.
module rs_drive_ctrl
    import rs_drive_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q,
    input  logic qb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int MAX_PG  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_ALL = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] PULSE_RELOAD   = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_RELOAD     = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] TIMEOUT_RELOAD = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    logic q_seen;
    logic qb_seen;

`ifdef RS_DRIVE_CTRL_SYNC_EN
    rs_sync2 u_sync_q (
        .clk (clk),
        .rst (rst),
        .d   (q),
        .q   (q_seen)
    );

    rs_sync2 u_sync_qb (
        .clk (clk),
        .rst (rst),
        .d   (qb),
        .q   (qb_seen)
    );
`else
    assign q_seen  = q;
    assign qb_seen = qb;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir;

    logic [1:0] seen;
    logic       one_req;
    logic       req_dir;
    logic       idle_match;
    logic       verify_match;

    assign seen         = {q_seen, qb_seen};
    assign one_req      = set_req ^ clr_req;
    assign req_dir      = set_req ? DIR_SET : DIR_CLR;
    // q==qb never equals a target pair, so it always counts as a mismatch.
    assign idle_match   = (seen == target_pair(req_dir));
    assign verify_match = (seen == target_pair(dir));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= DIR_CLR;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s <= 1'b0;
                    r <= 1'b0;
                    if (set_req && clr_req) begin
                        err <= 1'b1;
                    end else if (one_req) begin
                        dir  <= req_dir;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (idle_match) begin
                            done  <= 1'b1;
                            state <= GAP;
                            cnt   <= GAP_RELOAD;
                        end else begin
                            state <= PULSE;
                            cnt   <= PULSE_RELOAD;
                        end
                    end
                end

                // First PULSE cycle is a setup cycle; s/r then stay high for PULSE_W cycles.
                PULSE: begin
                    if (cnt != '0) begin
                        s   <= (dir == DIR_SET);
                        r   <= (dir == DIR_CLR);
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        s     <= 1'b0;
                        r     <= 1'b0;
                        state <= VERIFY;
                        cnt   <= TIMEOUT_RELOAD;
                    end
                end

                VERIFY: begin
                    s <= 1'b0;
                    r <= 1'b0;
                    if (verify_match) begin
                        done  <= 1'b1;
                        state <= GAP;
                        cnt   <= GAP_RELOAD;
                    end else if (cnt <= CNT_ONE) begin
                        err   <= 1'b1;
                        state <= GAP;
                        cnt   <= GAP_RELOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                GAP: begin
                    s <= 1'b0;
                    r <= 1'b0;
                    if (cnt <= CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_drive_ctrl.sv
// Directed bench: rs_drive_ctrl driving a behavioural NOR RS latch with 1-unit gate delays.
module tb_rs_drive_ctrl;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic s, r, busy, done, err;

    logic q_lat  = 1'b0;
    logic qb_lat = 1'b1;
    logic stuck  = 1'b0;
    logic q_in, qb_in;

    int total = 0;
    int bad   = 0;

    int sCyc, rCyc, doneCyc, busyCyc, overlap, sFirst, doneIdx;

    assign q_in  = stuck ? 1'b0 : q_lat;
    assign qb_in = stuck ? 1'b1 : qb_lat;

    always #5 clk = ~clk;

    rs_drive_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .clr_req (clr_req),
        .q       (q_in),
        .qb      (qb_in),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Cross-coupled NOR behaviour: the driven side's complement moves first, one gate delay each.
    always @(s or r) begin
        if (s && !r) begin
            #1 qb_lat = 1'b0;
            #1 q_lat  = 1'b1;
        end else if (r && !s) begin
            #1 q_lat  = 1'b0;
            #1 qb_lat = 1'b1;
        end else if (s && r) begin
            #1 q_lat  = 1'b0;
            qb_lat    = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic doSet, input logic doClr);
        set_req = doSet;
        clr_req = doClr;
        step();
        set_req = 1'b0;
        clr_req = 1'b0;
    endtask

    // Issues one request and profiles the whole busy window, sampled after each edge.
    task automatic runCmd(input logic doSet, input logic doClr);
        applyStimulus(doSet, doClr);
        sCyc = 0; rCyc = 0; doneCyc = 0; busyCyc = 0; overlap = 0;
        sFirst = -1; doneIdx = -1;
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            busyCyc++;
            if (s) begin
                sCyc++;
                if (sFirst < 0) sFirst = k;
            end
            if (r) rCyc++;
            if (s && r) overlap++;
            if (done) begin
                doneCyc++;
                if (doneIdx < 0) doneIdx = k;
            end
            step();
        end
        checkOutput("cmd_bound", busy, 0);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        step();
        step();
        checkOutput("rst_s", s, 0);
        checkOutput("rst_r", r, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;
        step();
        checkOutput("idle_busy", busy, 0);

        // Normal set from q=0
        runCmd(1'b1, 1'b0);
        checkOutput("set_s_cycles", sCyc, 4);
        checkOutput("set_s_first", sFirst, 1);
        checkOutput("set_r_cycles", rCyc, 0);
        checkOutput("set_done_cycles", doneCyc, 1);
        checkOutput("set_done_idx", doneIdx, 6);
        checkOutput("set_busy_cycles", busyCyc, 8);
        checkOutput("set_q", q_lat, 1);
        checkOutput("set_qb", qb_lat, 0);

        // Normal clear
        runCmd(1'b0, 1'b1);
        checkOutput("clr_r_cycles", rCyc, 4);
        checkOutput("clr_s_cycles", sCyc, 0);
        checkOutput("clr_done_cycles", doneCyc, 1);
        checkOutput("clr_busy_cycles", busyCyc, 8);
        checkOutput("clr_q", q_lat, 0);
        checkOutput("clr_qb", qb_lat, 1);
        checkOutput("clr_err", err, 0);

        // Conflicting requests
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_s", s, 0);
        checkOutput("both_r", r, 0);
        checkOutput("both_busy", busy, 0);
        checkOutput("both_err", err, 1);
        step();
        checkOutput("both_err_sticky", err, 1);
        checkOutput("both_stay_idle", busy, 0);
        runCmd(1'b1, 1'b0);
        checkOutput("after_both_err", err, 0);
        checkOutput("after_both_s", sCyc, 4);
        checkOutput("after_both_done", doneCyc, 1);

        // Stuck latch read-back during a set: timeout path
        runCmd(1'b0, 1'b1);
        stuck = 1'b1;
        runCmd(1'b1, 1'b0);
        checkOutput("stuck_s_cycles", sCyc, 4);
        checkOutput("stuck_done", doneCyc, 0);
        checkOutput("stuck_busy_cycles", busyCyc, 15);
        checkOutput("stuck_err", err, 1);
        stuck = 1'b0;

        // Request already satisfied (q=1 from the real latch)
        runCmd(1'b1, 1'b0);
        checkOutput("sat_s_cycles", sCyc, 0);
        checkOutput("sat_done_idx", doneIdx, 0);
        checkOutput("sat_done_cycles", doneCyc, 1);
        checkOutput("sat_busy_cycles", busyCyc, 2);
        checkOutput("sat_err", err, 0);

        // set_req during a busy clear is dropped, not queued
        applyStimulus(1'b0, 1'b1);
        sCyc = 0;
        set_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (s) sCyc++;
            step();
        end
        set_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            if (s) sCyc++;
            step();
        end
        checkOutput("ign_bound", busy, 0);
        checkOutput("ign_s_cycles", sCyc, 0);
        checkOutput("ign_q", q_lat, 0);
        step();
        step();
        checkOutput("ign_not_queued", busy, 0);

        // Asynchronous reset in the middle of PULSE
        applyStimulus(1'b1, 1'b0);
        step();
        checkOutput("mid_pre_s", s, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_s", s, 0);
        checkOutput("mid_rst_r", r, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_err", err, 0);
        step();
        rst = 1'b0;
        step();
        runCmd(1'b0, 1'b1);
        checkOutput("post_rst_r_cycles", rCyc, 4);
        checkOutput("post_rst_done", doneCyc, 1);
        checkOutput("post_rst_busy", busyCyc, 8);
        checkOutput("post_rst_q", q_lat, 0);
        checkOutput("post_rst_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
